nios_system_serial_rx: RTL and testbench
========================================

# nios_system_serial_rx

Serial byte receiver that sits directly upstream of the system's 8-bit Avalon PIO input port. It samples an asynchronous UART-style line (8N1, LSB first), reassembles each byte, and holds the last good byte on a level output wired straight to the PIO's `in_port`. It also provides a one-cycle `data_valid` strobe and sticky status flags for optional wiring to a second PIO or an IRQ input.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Legal range ≥ 4. `HALF` = `CLKS_PER_BIT/2`, integer division.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `rx`  in  1  asynchronous serial line; idle high.
- `data_out`  out  8  last byte received with a valid stop bit; feeds PIO `in_port`.
- `data_valid`  out  1  one-cycle strobe when `data_out` is updated.
- `frame_error`  out  1  set on a bad stop bit; cleared by the next good byte.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE. There is one bit counter `cnt` with width ceil(log2(CLKS_PER_BIT)), a 3-bit index `bit_idx`, and an 8-bit shift register `shreg`.
- IDLE: when `rx_s`==0, go to START with `cnt`=0.
- START: `cnt` increments each cycle. On the edge where `cnt`==HALF-1, sample `rx_s`:
  - 0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - 1: glitch; return to IDLE with no output change.
- DATA: `cnt` counts 0..CLKS_PER_BIT-1. On the edge where `cnt`==CLKS_PER_BIT-1:
  - `shreg` <= {`rx_s`, `shreg[7:1]`} (LSB first) and `cnt`=0.
  - If `bit_idx`==7, go to STOP; otherwise `bit_idx`++.
- STOP: same count. On the terminal edge:
  - `rx_s`==1: `data_out` <= `shreg`, `data_valid` <= 1, `frame_error` <= 0, go to IDLE.
  - `rx_s`==0: `frame_error` <= 1, `data_out` unchanged, no strobe, go to WAIT_IDLE.
- WAIT_IDLE (break/line-low): remain until `rx_s`==1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 bytes.
- `data_valid` is cleared every cycle it is not being set, so it is always exactly one cycle wide.
- `busy` = (state != IDLE), registered with the state.
- `data_out` holds indefinitely between bytes, which matches the PIO's level-sampling read.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_error`=0, `busy`=0, state=IDLE, `cnt`=0, `bit_idx`=0, `shreg`=0.
- Reset asserted mid-byte aborts immediately. The partial byte is discarded and `data_out` returns to 0x00.
- Let E be the edge where IDLE→START occurs. E is the 3rd rising edge after `rx` falls: 2 synchronizer edges plus the detect edge.
- Sample edges:
  - start bit at E+HALF;
  - data bit i (i=0..7) at E+HALF+(i+1)·CLKS_PER_BIT;
  - stop bit at S = E+HALF+9·CLKS_PER_BIT.
- `data_out` and `data_valid` change at edge S. `data_valid` deasserts at S+1.
- Back-to-back bytes: the FSM is in IDLE from S+1, so a start edge arriving at nominal bit timing (about HALF cycles after S) is accepted with no loss.
- A glitch on `rx` lasting fewer than HALF cycles (after synchronization) produces no strobe and no flag change.

## Test plan
- **Single byte.** CLKS_PER_BIT=8; send 0xA5 with a good stop bit. Required: `data_out`=0xA5 and a one-cycle `data_valid` at E+76; `frame_error`=0; `busy` high from E+1 through S.
- **Back-to-back bytes.** Send 0x00 then 0xFF with no idle gap beyond the stop bit. Required: two strobes, 80 cycles apart; `data_out` is 0x00 then 0xFF.
- **Framing error.** After a good 0x3C, send 0x81 with stop bit 0 and hold `rx` low for 40 cycles. Required: no strobe, `frame_error`=1, `data_out` stays 0x3C, and the FSM stays in WAIT_IDLE while low. On the next good byte 0x12: `frame_error`=0 and `data_out`=0x12.
- **Start glitch.** Pulse `rx` low for 2 cycles. Required: `busy` pulses briefly, no `data_valid`, `data_out` unchanged.
- **Reset mid-byte.** Assert `reset_n`=0 during data bit 4 of 0x5A. Required: all outputs return to reset values asynchronously. A subsequent 0xC3 is received correctly.
- **Idle stability.** Hold `rx` high for 1000 cycles. Required: `busy`=0, no strobes.

Source files
------------

// File: rtl/nios_system_serial_rx_if.sv
// Serial receiver signal bundle: the line input plus the byte/status outputs.
// The master modport is the receiver side; the slave modport is the line driver and PIO side.
interface nios_system_serial_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/nios_system_serial_rx.sv
// 8N1 UART receiver feeding a PIO in_port; holds the last good byte and strobes data_valid.
// Latency: data_out/data_valid update HALF+9*CLKS_PER_BIT cycles after the start-detect edge.
// No backpressure: the line is free-running, and the consumer samples the level output.
module nios_system_serial_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic                   clk,
  input logic                   reset_n,
  nios_system_serial_rx_if.master bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_out_q, data_out_nxt;
  logic          data_valid_q, data_valid_nxt;
  logic          frame_error_q, frame_error_nxt;
  logic          busy_q;

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_idx_nxt;
      shreg         <= shreg_nxt;
      data_out_q    <= data_out_nxt;
      data_valid_q  <= data_valid_nxt;
      frame_error_q <= frame_error_nxt;
      busy_q        <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    bit_idx_nxt     = bit_idx;
    shreg_nxt       = shreg;
    data_out_nxt    = data_out_q;
    data_valid_nxt  = 1'b0;
    frame_error_nxt = frame_error_q;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // Re-check the line mid start bit so short glitches are rejected.
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_out_nxt    = shreg;
            data_valid_nxt  = 1'b1;
            frame_error_nxt = 1'b0;
            state_nxt       = IDLE;
          end else begin
            frame_error_nxt = 1'b1;
            state_nxt       = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must not be decoded as a stream of 0x00 bytes.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_nios_system_serial_rx.sv
// Bench for nios_system_serial_rx at CLKS_PER_BIT=8: scoreboard of expected bytes and strobe cycles.
module tb_nios_system_serial_rx;
  localparam int CPB = 8;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   strobe_cnt = 0;
  logic prev_dv = 1'b0;
  exp_t sb[$];

  nios_system_serial_rx_if bus();

  nios_system_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest expected byte and its predicted cycle.
  always @(negedge clk) begin
    if (bus.data_valid) begin
      strobe_cnt++;
      vectors++;
      if (prev_dv) begin
        miscompares++;
        $display("FAIL strobe_width: data_valid high on consecutive cycles at cycle %0d", cyc);
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: data_out=%02h at cycle %0d, none expected", bus.data_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.data_out !== e.b || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL strobe_data: got %02h at cycle %0d, want %02h at cycle %0d",
                   bus.data_out, cyc, e.b, e.cyc);
        end
      end
    end
    prev_dv = bus.data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one full frame (start, 8 data LSB first, stop) of exactly 10*CPB cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    int t0;
    t0 = cyc;
    if (stop_bit) sb.push_back('{b: b, cyc: t0 + 79});
    bus.rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) tick();
    end
    bus.rx = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic test_reset();
    bus.rx  = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 ||
        bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out=%02h dv=%b fe=%b busy=%b, want 00 0 0 0",
               bus.data_out, bus.data_valid, bus.frame_error, bus.busy);
    end
    reset_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_single_byte();
    int t0;
    int busy_bad;
    busy_bad = 0;
    t0 = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (85) begin
          @(negedge clk);
          if (bus.busy !== ((cyc - t0) >= 3 && (cyc - t0) <= 78)) busy_bad++;
        end
      end
    join
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL single_busy: %0d cycles with wrong busy, want 0", busy_bad);
    end
    vectors++;
    if (bus.data_out !== 8'hA5 || bus.frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL single_byte: out=%02h fe=%b, want a5 0", bus.data_out, bus.frame_error);
    end
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) tick();
    vectors++;
    if (strobe_cnt - s0 != 2 || bus.data_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL back_to_back: strobes=%0d out=%02h, want 2 ff", strobe_cnt - s0, bus.data_out);
    end
    repeat (10) tick();
  endtask

  task automatic test_frame_error();
    int s0;
    send_byte(8'h3C, 1'b1);
    repeat (5) tick();
    s0 = strobe_cnt;
    send_byte(8'h81, 1'b0);
    repeat (40) tick();
    vectors++;
    if (bus.frame_error !== 1'b1 || bus.data_out !== 8'h3C || bus.busy !== 1'b1 ||
        strobe_cnt != s0) begin
      miscompares++;
      $display("FAIL frame_error_low: fe=%b out=%02h busy=%b strobes=%0d, want 1 3c 1 0",
               bus.frame_error, bus.data_out, bus.busy, strobe_cnt - s0);
    end
    bus.rx = 1'b1;
    repeat (20) tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.frame_error !== 1'b1 || strobe_cnt != s0) begin
      miscompares++;
      $display("FAIL frame_error_release: busy=%b fe=%b strobes=%0d, want 0 1 0",
               bus.busy, bus.frame_error, strobe_cnt - s0);
    end
    send_byte(8'h12, 1'b1);
    repeat (2) tick();
    vectors++;
    if (bus.frame_error !== 1'b0 || bus.data_out !== 8'h12) begin
      miscompares++;
      $display("FAIL frame_error_recover: fe=%b out=%02h, want 0 12", bus.frame_error, bus.data_out);
    end
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int   s0;
    logic busy_seen;
    logic [7:0] held;
    s0 = strobe_cnt;
    held = bus.data_out;
    busy_seen = 1'b0;
    bus.rx = 1'b0;
    repeat (2) tick();
    bus.rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    tick();
    vectors++;
    if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy: seen=%b now=%b, want 1 0", busy_seen, bus.busy);
    end
    vectors++;
    if (strobe_cnt != s0 || bus.data_out !== held || bus.frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_output: strobes=%0d out=%02h fe=%b, want 0 %02h 0",
               strobe_cnt - s0, bus.data_out, bus.frame_error, held);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_byte();
    fork
      send_byte(8'h5A, 1'b0);
      begin
        repeat (43) tick();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 ||
            bus.frame_error !== 1'b0 || bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_mid_byte: out=%02h dv=%b fe=%b busy=%b, want 00 0 0 0",
                   bus.data_out, bus.data_valid, bus.frame_error, bus.busy);
        end
      end
    join
    bus.rx = 1'b1;
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    send_byte(8'hC3, 1'b1);
    repeat (2) tick();
    vectors++;
    if (bus.data_out !== 8'hC3) begin
      miscompares++;
      $display("FAIL reset_recover: out=%02h, want c3", bus.data_out);
    end
    repeat (10) tick();
  endtask

  task automatic test_idle();
    int s0;
    int busy_hits;
    s0 = strobe_cnt;
    busy_hits = 0;
    bus.rx = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_hits++;
    end
    tick();
    vectors++;
    if (busy_hits != 0 || strobe_cnt != s0) begin
      miscompares++;
      $display("FAIL idle_stability: busy_cycles=%0d strobes=%0d, want 0 0", busy_hits, strobe_cnt - s0);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_byte();
    test_idle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: %0d expected bytes never arrived, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
